// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for 3-input gate blocks: applies all eight input vectors,
// waits SETTLE cycles per vector, compares against TRUTH and reports the result.
module gate_test_sequencer #(
    parameter int unsigned SETTLE = 2,
    parameter logic [7:0]  TRUTH  = 8'b1000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    // state | meaning
    // IDLE  | gate inputs 0, waiting for start
    // WAIT  | vector applied, settle counter running
    // CHECK | one cycle: y_in compared with TRUTH[vec]
    // DONE  | one cycle: done pulse, pass latched on exit
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam state_t     AFTER_VEC   = (SETTLE == 0) ? CHECK : WAIT;

    state_t     state, state_nxt;
    logic [2:0] vec, vec_nxt;
    logic [3:0] settle_cnt, settle_nxt;
    logic [3:0] err_nxt;
    logic       fvalid_nxt;
    logic [2:0] fvec_nxt;
    logic       pass_nxt;
    logic [2:0] gate_nxt;
    logic       mismatch;

    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec;
        settle_nxt = settle_cnt;
        err_nxt    = err_count;
        fvalid_nxt = fail_valid;
        fvec_nxt   = fail_vec;
        pass_nxt   = pass;
        mismatch   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    vec_nxt    = 3'd0;
                    err_nxt    = 4'd0;
                    fvalid_nxt = 1'b0;
                    fvec_nxt   = 3'd0;
                    pass_nxt   = 1'b0;
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = AFTER_VEC;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == 4'd0) begin
                    state_nxt = CHECK;
                end else begin
                    settle_nxt = settle_cnt - 4'd1;
                end
            end
            CHECK: begin
                // an abort cancels the comparison of the vector being checked
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    mismatch = (y_in != TRUTH[vec]);
                    if (mismatch) begin
                        err_nxt = err_count + 4'd1;
                        if (!fail_valid) begin
                            fvalid_nxt = 1'b1;
                            fvec_nxt   = vec;
                        end
                    end
                    if (vec == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt    = vec + 3'd1;
                        settle_nxt = SETTLE_LOAD;
                        state_nxt  = AFTER_VEC;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (!abort) begin
                    pass_nxt = (err_count == 4'd0);
                end
            end
            default: state_nxt = IDLE;
        endcase
        gate_nxt = (state_nxt == WAIT || state_nxt == CHECK) ? vec_nxt : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            c_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            settle_cnt <= settle_nxt;
            a_out      <= gate_nxt[2];
            b_out      <= gate_nxt[1];
            c_out      <= gate_nxt[0];
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
            pass       <= pass_nxt;
            err_count  <= err_nxt;
            fail_valid <= fvalid_nxt;
            fail_vec   <= fvec_nxt;
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: cycle-level timing model for the SETTLE=2 AND
// instance plus directed runs with literal expectations on three instances.
module tb_gate_test_sequencer;

    localparam int S0 = 2;
    localparam logic [7:0] AND_TT = 8'b1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic [2:0] start_v = 3'b000;
    int mode = 0;  // 0: correct AND, 1: stuck-at-0, 2: stuck-at-1

    logic [2:0] a_v, b_v, c_v, y_v, busy_v, done_v, pass_v, fvalid_v;
    logic [3:0] err_v [3];
    logic [2:0] fvec_v [3];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    assign y_v[0] = (mode == 0) ? (a_v[0] & b_v[0] & c_v[0]) : (mode == 2);
    assign y_v[1] = a_v[1] & b_v[1] & c_v[1];
    assign y_v[2] = a_v[2] & b_v[2] & c_v[2];

    gate_test_sequencer #(.SETTLE(2), .TRUTH(AND_TT)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .y_in(y_v[0]),
        .a_out(a_v[0]), .b_out(b_v[0]), .c_out(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err_v[0]), .fail_valid(fvalid_v[0]), .fail_vec(fvec_v[0]));

    gate_test_sequencer #(.SETTLE(2), .TRUTH(8'b1111_1110)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .y_in(y_v[1]),
        .a_out(a_v[1]), .b_out(b_v[1]), .c_out(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err_v[1]), .fail_valid(fvalid_v[1]), .fail_vec(fvec_v[1]));

    gate_test_sequencer #(.SETTLE(0), .TRUTH(AND_TT)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .y_in(y_v[2]),
        .a_out(a_v[2]), .b_out(b_v[2]), .c_out(c_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err_v[2]), .fail_valid(fvalid_v[2]), .fail_vec(fvec_v[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of u0: m_t counts cycles since accept (1 = first cycle after it);
    // vector n occupies cycles n*(S0+1)+1 .. n*(S0+1)+S0+1, the last being its check.
    bit m_run = 0, m_done_cyc = 0, m_pass = 0, m_fvalid = 0;
    int m_t = 0, m_err = 0, m_fvec = 0;

    always @(posedge clk) begin
        int n, ph, y_exp;
        if (rst) begin
            m_run = 0; m_done_cyc = 0; m_pass = 0; m_fvalid = 0;
            m_t = 0; m_err = 0; m_fvec = 0;
        end else if (m_done_cyc) begin
            m_done_cyc = 0;
            if (!abort) m_pass = (m_err == 0);
        end else if (m_run) begin
            if (abort) begin
                m_run = 0;
            end else begin
                n  = (m_t - 1) / (S0 + 1);
                ph = (m_t - 1) % (S0 + 1);
                if (ph == S0) begin
                    y_exp = (mode == 0) ? int'(n == 7) : ((mode == 2) ? 1 : 0);
                    if (y_exp != int'(AND_TT[n])) begin
                        m_err++;
                        if (!m_fvalid) begin
                            m_fvalid = 1;
                            m_fvec = n;
                        end
                    end
                end
                if (m_t == 8 * (S0 + 1)) begin
                    m_run = 0;
                    m_done_cyc = 1;
                end else begin
                    m_t++;
                end
            end
        end else if (start_v[0]) begin
            m_run = 1; m_t = 1; m_err = 0; m_fvalid = 0; m_fvec = 0; m_pass = 0;
        end
    end

    always @(negedge clk) begin
        int ev;
        if (cmp_en) begin
            ev = m_run ? (m_t - 1) / (S0 + 1) : 0;
            chk("cyc_busy", int'(busy_v[0]), int'(m_run | m_done_cyc));
            chk("cyc_done", int'(done_v[0]), int'(m_done_cyc));
            chk("cyc_vec", int'({a_v[0], b_v[0], c_v[0]}), ev);
            chk("cyc_pass", int'(pass_v[0]), int'(m_pass));
            chk("cyc_err", int'(err_v[0]), m_err);
            chk("cyc_fvalid", int'(fvalid_v[0]), int'(m_fvalid));
            if (m_fvalid) chk("cyc_fvec", int'(fvec_v[0]), m_fvec);
        end
    end

    // Pulse start on instance w, then apply rst/abort/extra start at cycle offset m
    // (m = 0 is the cycle after the accept edge). expect_m < 0 means no done pulse.
    task automatic run(input int w, input string name, input int expect_m,
                       input int rst_at, input int abort_at, input int restart_at);
        int m;
        bit seen;
        @(negedge clk);
        start_v[w] = 1'b1;
        @(negedge clk);
        m = 0;
        seen = 0;
        while (!seen && m < 60) begin
            if (done_v[w]) begin
                seen = 1;
            end else begin
                rst = (m == rst_at);
                abort = (m == abort_at);
                start_v[w] = (m == restart_at);
                @(negedge clk);
                m++;
            end
        end
        rst = 1'b0;
        abort = 1'b0;
        start_v[w] = 1'b0;
        if (expect_m >= 0) chk({name, "_done_edge"}, seen ? m : -1, expect_m);
        else chk({name, "_no_done"}, int'(seen), 0);
        @(negedge clk);
    endtask

    task automatic result(input int w, input string name, input int p, input int e,
                          input int fv, input int fvec);
        chk({name, "_pass"}, int'(pass_v[w]), p);
        chk({name, "_err"}, int'(err_v[w]), e);
        chk({name, "_fvalid"}, int'(fvalid_v[w]), fv);
        if (fv != 0) chk({name, "_fvec"}, int'(fvec_v[w]), fvec);
        chk({name, "_busy"}, int'(busy_v[w]), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        for (int w = 0; w < 3; w++) begin
            chk("rst_vec", int'({a_v[w], b_v[w], c_v[w]}), 0);
            result(w, "rst", 0, 0, 0, 0);
        end

        mode = 0;
        run(0, "and_ok", 24, -1, -1, -1);
        result(0, "and_ok", 1, 0, 0, 0);

        mode = 1;
        run(0, "stuck0", 24, -1, -1, -1);
        result(0, "stuck0", 0, 1, 1, 7);

        mode = 2;
        run(0, "stuck1", 24, -1, -1, -1);
        result(0, "stuck1", 0, 7, 1, 0);

        run(1, "or_tt", 24, -1, -1, -1);
        result(1, "or_tt", 0, 6, 1, 1);

        run(2, "s0", 8, -1, -1, 3);
        result(2, "s0", 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("s0_no_requeue", int'(busy_v[2]), 0);

        mode = 0;
        run(0, "rst_mid", -1, 12, -1, -1);
        result(0, "rst_mid", 0, 0, 0, 0);
        run(0, "after_rst", 24, -1, -1, -1);
        result(0, "after_rst", 1, 0, 0, 0);

        mode = 2;
        run(0, "abort", -1, -1, 15, -1);
        result(0, "abort", 0, 5, 1, 0);

        // start and abort together in IDLE: start wins
        @(negedge clk);
        abort = 1'b1;
        run(0, "start_vs_abort", 24, -1, -1, -1);
        result(0, "start_vs_abort", 0, 7, 1, 0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
